// File: rtl/cache_controller.sv
// cache_controller: sequences the 2-way data cache and the SRAM controller for the MEM stage.
// Reads hit in the cache with zero stall. Misses fetch a 64-bit line, fill the cache and
// return the requested word. Writes are write-through, no-allocate: invalidate, then SRAM write.
// Optional feature macro: CACHE_PERF_COUNTERS_EN adds saturating hit/miss counters.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR    = 32'd1024,
    parameter int unsigned CACHE_ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic [CACHE_ADDR_W-1:0] cache_addr,
    output logic                    cache_r_en,
    output logic                    cache_w_en,
    output logic                    cache_invalidate,
    output logic [63:0]             cache_wdata,
    input  logic                    cache_hit,
    input  logic [31:0]             cache_rdata,
    output logic                    sram_r_en,
    output logic                    sram_w_en,
    output logic [31:0]             sram_addr,
    output logic [31:0]             sram_wdata,
    input  logic [63:0]             sram_rdata,
    input  logic                    sram_ready
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    typedef enum logic [1:0] {StIdle, StRdMiss, StFill, StWr} state_e;

    state_e      state_q, state_d;
    logic [63:0] line_q, line_d;
    logic [31:0] addr_off;

    // Address translation is purely combinational; the requester holds addr until ready.
    assign addr_off    = addr - BASE_ADDR;
    assign sram_addr   = addr_off;
    assign cache_addr  = addr_off[CACHE_ADDR_W-1:0];
    assign sram_wdata  = wdata;
    assign cache_wdata = line_q;

    // Next-state and output decode; stores win over loads when both are requested.
    always_comb begin
        state_d          = state_q;
        line_d           = line_q;
        ready            = 1'b0;
        rdata            = 32'd0;
        cache_r_en       = 1'b0;
        cache_w_en       = 1'b0;
        cache_invalidate = 1'b0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_w_en) begin
                    cache_invalidate = 1'b1;
                    state_d          = StWr;
                end else if (mem_r_en) begin
                    if (cache_hit) begin
                        cache_r_en = 1'b1;
                        rdata      = cache_rdata;
                        ready      = 1'b1;
                    end else begin
                        state_d = StRdMiss;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            StRdMiss: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    line_d  = sram_rdata;
                    state_d = StFill;
                end
            end
            StFill: begin
                cache_w_en = 1'b1;
                rdata      = addr[2] ? line_q[63:32] : line_q[31:0];
                ready      = 1'b1;
                state_d    = StIdle;
            end
            StWr: begin
                sram_w_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and line buffer; reset abandons any in-flight SRAM op without filling the cache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            line_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        hit_evt, miss_evt;

    // Count read hits and misses seen in IDLE, saturating at all-ones.
    always_comb begin
        hit_evt      = (state_q == StIdle) && !mem_w_en && mem_r_en && cache_hit;
        miss_evt     = (state_q == StIdle) && !mem_w_en && mem_r_en && !cache_hit;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_evt && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_evt && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed bench with a small SRAM latency model and an rdata scoreboard.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [18:0] cache_addr;
    logic        cache_r_en, cache_w_en, cache_invalidate;
    logic [63:0] cache_wdata;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        sram_r_en, sram_w_en;
    logic [31:0] sram_addr, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .addr             (addr),
        .wdata            (wdata),
        .rdata            (rdata),
        .ready            (ready),
        .cache_addr       (cache_addr),
        .cache_r_en       (cache_r_en),
        .cache_w_en       (cache_w_en),
        .cache_invalidate (cache_invalidate),
        .cache_wdata      (cache_wdata),
        .cache_hit        (cache_hit),
        .cache_rdata      (cache_rdata),
        .sram_r_en        (sram_r_en),
        .sram_w_en        (sram_w_en),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata),
        .sram_ready       (sram_ready)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    // Per-transaction observations gathered by run_req.
    int          stalls, inv_cnt, fill_cnt;
    logic        done, saw_sr, saw_sw, crd_rdy;
    logic [31:0] sa0, wd_seen;
    logic [18:0] ca0;
    logic [63:0] fill_line;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at posedge+1 and run until ready (bounded). The SRAM model raises
    // sram_ready on the lat-th consecutive cycle of an SRAM request.
    task automatic run_req(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic hit, input logic [31:0] crd,
                           input int lat);
        int          busy;
        logic [31:0] e;
        busy = 0; done = 0; stalls = 0; saw_sr = 0; saw_sw = 0; inv_cnt = 0; fill_cnt = 0;
        crd_rdy = 0; wd_seen = '0; fill_line = '0; sa0 = '0; ca0 = '0;
        addr = a; mem_r_en = rd; mem_w_en = wr; wdata = wd; cache_hit = hit;
        cache_rdata = crd; sram_ready = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (sram_r_en || sram_w_en) begin
                busy++;
                sram_ready = (busy == lat);
            end else begin
                busy = 0;
                sram_ready = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                sa0 = sram_addr;
                ca0 = cache_addr;
            end
            if (sram_r_en) saw_sr = 1'b1;
            if (sram_w_en) begin
                saw_sw  = 1'b1;
                wd_seen = sram_wdata;
            end
            if (cache_invalidate) inv_cnt++;
            if (cache_w_en) begin
                fill_cnt++;
                fill_line = cache_wdata;
            end
            if (ready) begin
                done    = 1'b1;
                crd_rdy = cache_r_en;
                if (rd && !wr) begin
                    if (exp_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rdata", {32'd0, rdata}, {32'd0, e});
                    end
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0; cache_hit = 1'b0;
        chk("done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        logic bad;
        rst = 1'b0; mem_r_en = 0; mem_w_en = 0; addr = 32'd0; wdata = 32'd0;
        cache_hit = 0; cache_rdata = 32'd0; sram_rdata = 64'd0; sram_ready = 0;

        // Reset state
        #3;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_enables",
            {59'd0, cache_r_en, cache_w_en, cache_invalidate, sram_r_en, sram_w_en}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Cold read miss at 0x408 (addr[2]=0 selects the low word), 3-cycle SRAM
        sram_rdata = 64'hAAAA_BBBB_1111_2222;
        exp_q.push_back(32'h1111_2222);
        run_req(32'h408, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 3);
        chk("miss_sram_addr", {32'd0, sa0}, 64'h8);
        chk("miss_cache_addr", {45'd0, ca0}, 64'h8);
        chk("miss_stalls", stalls, 4);
        chk("miss_fill_cnt", fill_cnt, 1);
        chk("miss_fill_line", fill_line, 64'hAAAA_BBBB_1111_2222);

        // Hit at the same address
        exp_q.push_back(32'hAAAA_BBBB);
        run_req(32'h408, 1'b1, 1'b0, 32'd0, 1'b1, 32'hAAAA_BBBB, 3);
        chk("hit_stalls", stalls, 0);
        chk("hit_no_sram_r", {63'd0, saw_sr}, 64'd0);
        chk("hit_cache_r_en", {63'd0, crd_rdy}, 64'd1);

        // Miss at 0x40C selects the high word, 1-cycle SRAM
        sram_rdata = 64'h5555_6666_7777_8888;
        exp_q.push_back(32'h5555_6666);
        run_req(32'h40C, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1);
        chk("miss2_cache_addr", {45'd0, ca0}, 64'hC);
        chk("miss2_stalls", stalls, 2);
        chk("miss2_fill_line", fill_line, 64'h5555_6666_7777_8888);

        // Store, 5-cycle SRAM
        run_req(32'h400, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 5);
        chk("wr_sram_addr", {32'd0, sa0}, 64'h0);
        chk("wr_inv_cnt", inv_cnt, 1);
        chk("wr_stalls", stalls, 5);
        chk("wr_sram_w", {63'd0, saw_sw}, 64'd1);
        chk("wr_wdata", {32'd0, wd_seen}, 64'h1234_5678);
        chk("wr_no_fill", fill_cnt, 0);

        // Simultaneous load+store at addr 0: store wins; address offset wraps
        run_req(32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd0, 2);
        chk("both_no_sram_r", {63'd0, saw_sr}, 64'd0);
        chk("both_sram_w", {63'd0, saw_sw}, 64'd1);
        chk("both_stalls", stalls, 2);
        chk("wrap_sram_addr", {32'd0, sa0}, 64'hFFFF_FC00);
        chk("wrap_cache_addr", {45'd0, ca0}, 64'h7FC00);

        // Store dropped after the first cycle still completes with a ready pulse
        addr = 32'h420; wdata = 32'h0BAD_BEEF; mem_w_en = 1'b1;
        @(posedge clk); #1;
        mem_w_en = 1'b0;
        @(negedge clk);
        chk("drop_sram_w", {63'd0, sram_w_en}, 64'd1);
        chk("drop_ready_lo", {63'd0, ready}, 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        chk("drop_ready_hi", {63'd0, ready}, 64'd1);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        chk("drop_idle", {63'd0, sram_w_en}, 64'd0);
        @(posedge clk); #1;

        // Reset asserted while in RD_MISS
        addr = 32'h410; mem_r_en = 1'b1; cache_hit = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_pre", {63'd0, sram_r_en}, 64'd1);
        #1 rst = 1'b0;
        #1 chk("rst_mid_srd", {63'd0, sram_r_en}, 64'd0);
        mem_r_en = 1'b0;
        #1 chk("rst_mid_ready", {63'd0, ready}, 64'd1);
        @(negedge clk); rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cache_w_en || sram_r_en || !ready) bad = 1'b1;
        end
        chk("rst_mid_after", {63'd0, bad}, 64'd0);
        @(posedge clk); #1;

`ifdef CACHE_PERF_COUNTERS_EN
        // Counters were cleared by the reset above: 1 miss then 3 hits
        sram_rdata = 64'h0000_0001_0000_0002;
        exp_q.push_back(32'h0000_0002);
        run_req(32'h500, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 2);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h100 + i);
            run_req(32'h500, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100 + i, 2);
        end
        chk("perf_miss", {32'd0, miss_count}, 64'd1);
        chk("perf_hit", {32'd0, hit_count}, 64'd3);
`endif

        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
